// File: rtl/bpred_resolve.sv
// Execute-side branch resolution: queues fetch predictions, compares each against the
// resolved outcome, drives the predictor update port and a fetch redirect on mispredict.
module bpred_resolve #(
   parameter int DEPTH        = 8,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_push,
   input  logic [31:0]              fetch_PC,
   input  logic                     fetch_p_dir,
   input  logic [31:0]              fetch_p_target,
   input  logic [3:0]               fetch_meta,
   input  logic [95:0]              fetch_data,
   output logic                     fetch_full,
   output logic [$clog2(DEPTH):0]   occupancy,
   input  logic                     execute_valid,
   output logic                     execute_ready,
   input  logic                     execute_dir,
   input  logic [31:0]              execute_target,
   input  logic                     soin_bpredictor_stall,
   output logic                     execute_bpredictor_update,
   output logic [31:0]              execute_bpredictor_PC4,
   output logic [31:0]              execute_bpredictor_target,
   output logic                     execute_bpredictor_dir,
   output logic                     execute_bpredictor_miss,
   output logic [95:0]              execute_bpredictor_data,
   output logic [3:0]               execute_bpredictor_meta,
   output logic                     execute_bpredictor_recover_ras,
   output logic                     fetch_redirect,
   output logic [31:0]              fetch_redirect_PC
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FLUSH, HOLD} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        p_dir;
      logic [31:0] p_target;
      logic [3:0]  meta;
      logic [95:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   state_t        state;
   logic [CW-1:0] flush_cnt;

   entry_t        head;
   logic          hold_req, accept, miss, flush_q, wrong_path, push_ok;
   logic [31:0]   head_pc4;

   assign head       = mem[rd_ptr];
   assign head_pc4   = head.pc + 32'd4;
   assign fetch_full = (count == (AW+1)'(DEPTH));
   assign occupancy  = count;

   // A stalled update must stay intact, so no new resolution is taken while it is pending.
   assign hold_req      = execute_bpredictor_update && soin_bpredictor_stall;
   assign execute_ready = (count != '0) && (state == IDLE) && !hold_req;
   assign accept        = execute_valid && execute_ready;
   assign miss          = (head.p_dir != execute_dir) ||
                          (execute_dir && (head.p_target != execute_target));
   assign flush_q       = accept && miss;
   assign wrong_path    = (flush_cnt != '0);
   assign push_ok       = fetch_push && !wrong_path && !flush_q && (!fetch_full || accept);

   assign execute_bpredictor_recover_ras = execute_bpredictor_miss;

   // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= '{pc: fetch_PC, p_dir: fetch_p_dir, p_target: fetch_p_target,
                          meta: fetch_meta, data: fetch_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_q) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         count <= count + (AW+1)'(push_ok) - (AW+1)'(accept);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                     <= IDLE;
         flush_cnt                 <= '0;
         execute_bpredictor_update <= 1'b0;
         execute_bpredictor_PC4    <= '0;
         execute_bpredictor_target <= '0;
         execute_bpredictor_dir    <= 1'b0;
         execute_bpredictor_miss   <= 1'b0;
         execute_bpredictor_data   <= '0;
         execute_bpredictor_meta   <= '0;
         fetch_redirect            <= 1'b0;
         fetch_redirect_PC         <= '0;
      end else begin
         fetch_redirect            <= flush_q;
         execute_bpredictor_update <= accept || hold_req;
         if (accept) begin
            execute_bpredictor_PC4    <= head_pc4;
            execute_bpredictor_target <= execute_target;
            execute_bpredictor_dir    <= execute_dir;
            execute_bpredictor_miss   <= miss;
            execute_bpredictor_data   <= head.data;
            execute_bpredictor_meta   <= head.meta;
            fetch_redirect_PC         <= execute_dir ? execute_target : head_pc4;
         end

         // The flush window keeps counting down while an update is held.
         if (flush_q)
            flush_cnt <= CW'(FLUSH_CYCLES);
         else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;

         case (state)
            IDLE:    if (flush_q) state <= FLUSH;
                     else if (hold_req) state <= HOLD;
            FLUSH:   if (hold_req) state <= HOLD;
                     else if (flush_cnt == CW'(1)) state <= IDLE;
            HOLD:    if (!soin_bpredictor_stall)
                        state <= (flush_cnt > CW'(1)) ? FLUSH : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bpred_resolve.md
Name: bpred_resolve

Overview:
- Execute-side counterpart of the branch predictor. Each fetch-time prediction is queued with its metadata.
- When execute resolves the oldest in-flight branch, the block compares the actual outcome against the prediction. It then drives the predictor update interface (execute_bpredictor_*) and, on a mispredict, a fetch redirect plus a queue flush.
- Sits between fetch, the execute stage and bpredTop.

Parameters:
- DEPTH, 8: in-flight prediction queue entries (power of 2, >=2).
- FLUSH_CYCLES, 1: cycles after a redirect during which fetch pushes are discarded as wrong-path.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_push  in  1  push one prediction record.
- fetch_PC  in  32  PC of predicted branch.
- fetch_p_dir  in  1  predicted direction (1 = taken).
- fetch_p_target  in  32  predicted target.
- fetch_meta  in  4  predictor meta, returned unchanged.
- fetch_data  in  96  predictor history/data, returned unchanged.
- fetch_full  out  1  queue full; a push while full is dropped.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- execute_valid  in  1  oldest branch resolved this cycle.
- execute_ready  out  1  block can accept a resolution.
- execute_dir  in  1  actual direction.
- execute_target  in  32  actual taken target.
- soin_bpredictor_stall  in  1  predictor cannot accept an update.
- execute_bpredictor_update  out  1  update valid.
- execute_bpredictor_PC4  out  32  entry PC + 4.
- execute_bpredictor_target  out  32  actual target.
- execute_bpredictor_dir  out  1  actual direction.
- execute_bpredictor_miss  out  1  mispredict flag.
- execute_bpredictor_data  out  96  entry data.
- execute_bpredictor_meta  out  4  entry meta.
- execute_bpredictor_recover_ras  out  1  equals miss.
- fetch_redirect  out  1  one-cycle redirect pulse.
- fetch_redirect_PC  out  32  correct-path PC.

Behaviour:
- Reset (async assert, sync release): queue empty, occupancy 0, state IDLE, all outputs 0.
- Queue: circular FIFO with wrapping read/write pointers and an occupancy counter.
  - fetch_full = (occupancy == DEPTH).
  - A push while full is dropped and the counter is unchanged.
  - A push and pop in the same cycle while full are both accepted; occupancy stays DEPTH.
- Resolution accepted when execute_valid && execute_ready.
  - execute_ready = (occupancy != 0) && state == IDLE.
  - execute_valid while not ready is ignored. Nothing pops and no update is issued.
- Accepted resolution pops the head entry E and compares it with the actual outcome:
  - miss = (E.p_dir != execute_dir) || (execute_dir && E.p_target != execute_target).
  - PC4 = E.PC + 32'd4, wraps modulo 2^32.
  - Redirect PC = execute_dir ? execute_target : PC4.
- Latency: outputs are registered and appear the cycle after acceptance.
  - execute_bpredictor_update is high for one cycle with all fields from E and the actual outcome.
  - recover_ras = miss.
- Mispredict:
  - Same cycle as the update, fetch_redirect = 1 for exactly one cycle, with fetch_redirect_PC.
  - On the acceptance edge the whole queue is cleared (occupancy 0), including any push in that cycle.
  - The state then enters FLUSH for FLUSH_CYCLES cycles. Pushes are discarded and execute_ready = 0.
  - The state then returns to IDLE.
- Stall: if soin_bpredictor_stall = 1 in a cycle where update is high, enter HOLD.
  - update and all execute_bpredictor_* fields stay constant until the first cycle with stall = 0.
  - update drops the cycle after that first stall = 0 cycle.
  - fetch_redirect is not repeated during HOLD.
  - execute_ready = 0 in HOLD; pushes continue normally, except during the FLUSH window.
  - After HOLD, go to FLUSH if the held update was a miss and the flush window is not yet done, else IDLE.
- States: IDLE -> (accept, hit) IDLE; (accept, miss) FLUSH; (update && stall) HOLD; HOLD -> (!stall) FLUSH/IDLE; FLUSH -> (count done) IDLE.
- Reset mid-HOLD or mid-FLUSH: immediate return to the reset values above.

Test Plan:
- Push PC=0x100, p_dir=1, p_target=0x200; resolve dir=1, target=0x200. Next cycle: update=1, PC4=0x104, miss=0, no redirect; occupancy 1->0.
- Push 3 entries; the first (PC=0x40, p_dir=0) resolves with dir=1, target=0x80. Next cycle: update=1, miss=1, recover_ras=1, redirect=1, redirect_PC=0x80. Occupancy 0; a push in the following cycle is discarded; ready returns afterwards.
- Push PC=0xFFFFFFFC with p_dir=1, resolve dir=0. Required: PC4=0x0, miss=1, redirect_PC=0x0 (wrap).
- Fill 8 entries; fetch_full=1; a 9th push is dropped (occupancy 8). A simultaneous push+pop (hit) keeps occupancy 8, and FIFO order is verified over 8 further pops.
- Hold soin_bpredictor_stall=1 for 3 cycles on a miss update. Required: update and fields held stable 4 cycles, redirect pulses once, ready=0 throughout.
- Assert reset low mid-HOLD with 5 entries queued. Required: all outputs 0 and occupancy 0 immediately, without waiting for a clock edge.
